// File: rtl/proc_seq.sv
// Multi-cycle processor core: FETCH -> DECODE -> EXEC -> WRITE, with jumps,
// HALT and a single-step PAUSE state. Register file and data memory clear on reset.
module proc_seq #(
  parameter int OPCODE_WIDTH = 4,
  parameter int VALUE_WIDTH  = 8,
  parameter int MEM_WIDTH    = 4,
  parameter int PC_WIDTH     = 8,
  localparam int INSTR_WIDTH = OPCODE_WIDTH + 3 * (MEM_WIDTH + 2)
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_req,
  output logic [PC_WIDTH-1:0]     imem_addr,
  input  logic                    imem_valid,
  input  logic [INSTR_WIDTH-1:0]  imem_data,
  input  logic                    step_en,
  input  logic                    step,
  output logic                    halted,
  output logic [OPCODE_WIDTH-1:0] op_code,
  output logic [VALUE_WIDTH-1:0]  alu_out,
  output logic [MEM_WIDTH-1:0]    source1_addr,
  output logic [MEM_WIDTH-1:0]    source2_addr,
  output logic [MEM_WIDTH-1:0]    dest_addr,
  output logic [1:0]              source1_choice,
  output logic [1:0]              source2_choice,
  output logic [1:0]              dest_choice,
  output logic                    zero_flag,
  output logic                    carry_flag
);
  localparam int DEPTH = 2 ** MEM_WIDTH;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_OR   = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR  = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_MOV  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ   = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT = OPCODE_WIDTH'(15);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WRITE, S_PAUSE, S_HALT} state_t;

  state_t                 state, state_next;
  logic [PC_WIDTH-1:0]    pc;
  logic [VALUE_WIDTH-1:0] rf   [DEPTH];
  logic [VALUE_WIDTH-1:0] dmem [DEPTH];
  logic [VALUE_WIDTH-1:0] a_reg, b_reg, a_val, b_val;
  logic [VALUE_WIDTH-1:0] alu_res;
  logic                   alu_carry;
  logic [VALUE_WIDTH:0]   sum, diff;
  logic                   is_alu_op;

  assign imem_req  = (state == S_FETCH) && !rst;
  assign imem_addr = pc;
  assign halted    = (state == S_HALT);
  assign is_alu_op = (op_code >= OP_ADD) && (op_code <= OP_MOV);

  // Operand resolution; choice 11 reads as constant zero.
  always_comb begin
    a_val = '0;
    b_val = '0;
    case (source1_choice)
      2'b00:   a_val = rf[source1_addr];
      2'b01:   a_val = dmem[source1_addr];
      2'b10:   a_val = VALUE_WIDTH'(source1_addr);
      default: a_val = '0;
    endcase
    case (source2_choice)
      2'b00:   b_val = rf[source2_addr];
      2'b01:   b_val = dmem[source2_addr];
      2'b10:   b_val = VALUE_WIDTH'(source2_addr);
      default: b_val = '0;
    endcase
  end

  // The extra MSB of the difference is the borrow.
  assign sum  = {1'b0, a_reg} + {1'b0, b_reg};
  assign diff = {1'b0, a_reg} - {1'b0, b_reg};

  always_comb begin
    alu_res   = alu_out;
    alu_carry = 1'b0;
    case (op_code)
      OP_ADD:  begin alu_res = sum[VALUE_WIDTH-1:0];  alu_carry = sum[VALUE_WIDTH];  end
      OP_SUB:  begin alu_res = diff[VALUE_WIDTH-1:0]; alu_carry = diff[VALUE_WIDTH]; end
      OP_AND:  alu_res = a_reg & b_reg;
      OP_OR:   alu_res = a_reg | b_reg;
      OP_XOR:  alu_res = a_reg ^ b_reg;
      OP_MOV:  alu_res = a_reg;
      default: alu_res = alu_out;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (imem_valid) state_next = S_DECODE;
      S_DECODE: state_next = S_EXEC;
      S_EXEC:   state_next = S_WRITE;
      S_WRITE: begin
        if (op_code == OP_HALT) state_next = S_HALT;
        else if (step_en)       state_next = S_PAUSE;
        else                    state_next = S_FETCH;
      end
      S_PAUSE:  if (step || !step_en) state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_FETCH;
      pc             <= '0;
      op_code        <= '0;
      dest_choice    <= '0;
      dest_addr      <= '0;
      source1_choice <= '0;
      source1_addr   <= '0;
      source2_choice <= '0;
      source2_addr   <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      alu_out        <= '0;
      zero_flag      <= 1'b0;
      carry_flag     <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_FETCH && imem_valid)
        {op_code, dest_choice, dest_addr, source1_choice, source1_addr,
         source2_choice, source2_addr} <= imem_data;
      if (state == S_DECODE) begin
        a_reg <= a_val;
        b_reg <= b_val;
      end
      if (state == S_EXEC && is_alu_op) begin
        alu_out    <= alu_res;
        zero_flag  <= (alu_res == '0);
        carry_flag <= alu_carry;
      end
      if (state == S_WRITE) begin
        if (op_code == OP_JMP)
          pc <= PC_WIDTH'(a_reg);
        else if (op_code == OP_JZ)
          pc <= (b_reg == '0) ? PC_WIDTH'(a_reg) : pc + 1'b1;
        else if (op_code != OP_HALT)
          pc <= pc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf[i]   <= '0;
        dmem[i] <= '0;
      end
    end else if (state == S_WRITE && is_alu_op) begin
      if (dest_choice == 2'b00) rf[dest_addr]   <= alu_out;
      if (dest_choice == 2'b01) dmem[dest_addr] <= alu_out;
    end
  end
endmodule
